// File: rtl/rv32_m_arb_pkg.sv
// Shared types for the RV32M arbiter: FSM states, captured request slot and
// field widths.
package rv32_m_arb_pkg;

  localparam int F3_W = 3;
  // Core operand width; kept equal to the core-wide `XLEN.
  localparam int ARB_XLEN = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ARB_XLEN-1:0] rs1;
    logic [ARB_XLEN-1:0] rs2;
    logic [F3_W-1:0]     f3;
  } m_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner
// and wraps modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_grant_idx
);

  localparam int W = $clog2(N);

  always_comb begin
    logic [W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    o_valid     = 1'b0;
    o_grant_idx = '0;
    idx         = '0;
    // Walk from the farthest offset to the nearest so the nearest pending
    // requester is written last and wins.
    for (int off = N; off >= 1; off--) begin
      idx = W'((int'(i_last) + off) % N);
      if (i_req[idx]) begin
        o_valid     = 1'b1;
        o_grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rv32_m_arbiter.sv
// Shares one RV32M multiply/divide unit among N_REQ cores: one request slot
// per core, round-robin grant, one operation in flight at a time.
module rv32_m_arbiter
  import rv32_m_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = ARB_XLEN
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_en,
  input  logic [N_REQ-1:0][XLEN-1:0] i_req_rs1,
  input  logic [N_REQ-1:0][XLEN-1:0] i_req_rs2,
  input  logic [N_REQ-1:0][F3_W-1:0] i_req_f3,
  output logic [N_REQ-1:0]           o_req_ack,
  output logic [N_REQ-1:0][XLEN-1:0] o_req_res,
  output logic                       o_m_en,
  output logic [XLEN-1:0]            o_m_rs1,
  output logic [XLEN-1:0]            o_m_rs2,
  output logic [F3_W-1:0]            o_m_f3,
  input  logic [XLEN-1:0]            i_m_res,
  input  logic                       i_m_ack
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state, state_next;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] clear_mask;
  m_req_t           slot [N_REQ];
  logic [IDX_W-1:0] grant, last_grant, arb_idx;
  logic             arb_valid, issue, done;

  // A pulse is only taken into an empty slot; a second pulse while pending
  // (including the ack cycle) leaves the captured operands untouched.
  assign accept     = i_req_en & ~pending;
  assign clear_mask = done ? (N_REQ'(1) << grant) : '0;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req       (pending),
    .i_last      (last_grant),
    .o_valid     (arb_valid),
    .o_grant_idx (arb_idx)
  );

  // NOTE: slot payloads carry no reset; they are only read once the matching
  // pending bit (which is reset) has been set by a capture.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_REQ; k++) begin
      if (accept[k]) begin
        slot[k] <= '{rs1: i_req_rs1[k], rs2: i_req_rs2[k], f3: i_req_f3[k]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done       = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (arb_valid) begin
          issue      = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (i_m_ack) begin
          done       = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pending    <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      o_m_en     <= 1'b0;
      o_m_rs1    <= '0;
      o_m_rs2    <= '0;
      o_m_f3     <= '0;
      o_req_ack  <= '0;
      o_req_res  <= '0;
    end else begin
      pending   <= (pending | accept) & ~clear_mask;
      o_m_en    <= issue;
      o_req_ack <= '0;
      // Operand registers only change on a grant, so they hold through BUSY.
      if (issue) begin
        o_m_rs1 <= slot[arb_idx].rs1;
        o_m_rs2 <= slot[arb_idx].rs2;
        o_m_f3  <= slot[arb_idx].f3;
        grant   <= arb_idx;
      end
      if (done) begin
        o_req_ack[grant] <= 1'b1;
        o_req_res[grant] <= i_m_res;
        last_grant       <= grant;
      end
    end
  end

endmodule

// File: tb/tb_rv32_m_arbiter.sv
// Directed bench for rv32_m_arbiter with a queue-based scoreboard watching
// every M-unit start and every per-core ack.
module tb_rv32_m_arbiter;

  localparam int N = 3;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
  } iss_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] res;
  } ack_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic [N-1:0]         i_req_en = '0;
  logic [N-1:0][31:0]   i_req_rs1 = '0;
  logic [N-1:0][31:0]   i_req_rs2 = '0;
  logic [N-1:0][2:0]    i_req_f3 = '0;
  logic [N-1:0]         o_req_ack;
  logic [N-1:0][31:0]   o_req_res;
  logic                 o_m_en;
  logic [31:0]          o_m_rs1, o_m_rs2;
  logic [2:0]           o_m_f3;
  logic [31:0]          i_m_res = '0;
  logic                 i_m_ack = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  iss_t exp_iss[$];
  ack_t exp_ack[$];

  rv32_m_arbiter #(.N_REQ(N), .XLEN(32)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req_en  (i_req_en),
    .i_req_rs1 (i_req_rs1),
    .i_req_rs2 (i_req_rs2),
    .i_req_f3  (i_req_f3),
    .o_req_ack (o_req_ack),
    .o_req_res (o_req_res),
    .o_m_en    (o_m_en),
    .o_m_rs1   (o_m_rs1),
    .o_m_rs2   (o_m_rs2),
    .o_m_f3    (o_m_f3),
    .i_m_res   (i_m_res),
    .i_m_ack   (i_m_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every start and every ack must match the head of its queue.
  always @(negedge i_clk) begin
    iss_t ei;
    ack_t ea;
    if (i_rst) begin
      if (o_m_en) begin
        if (exp_iss.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          ei = exp_iss.pop_front();
          check("issue_ops", {o_m_rs1, o_m_rs2, o_m_f3}, {ei.rs1, ei.rs2, ei.f3});
        end
      end
      if (o_req_ack != '0) begin
        if (exp_ack.size() == 0) begin
          check("unexpected_ack", {29'd0, o_req_ack}, 0);
        end else begin
          ea = exp_ack.pop_front();
          check("ack_onehot", o_req_ack, 3'(1) << ea.idx);
          check("ack_res", o_req_res[ea.idx], ea.res);
        end
      end
    end
  end

  task automatic set_req(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input bit expect_issue);
    i_req_en[k]  = 1'b1;
    i_req_rs1[k] = a;
    i_req_rs2[k] = b;
    i_req_f3[k]  = f;
    if (expect_issue) exp_iss.push_back('{a, b, f});
  endtask

  task automatic wait_en(input int budget);
    int c;
    c = 0;
    while (!o_m_en && c < budget) begin
      step();
      c++;
    end
    check("start_seen", o_m_en, 1);
  endtask

  // Called in a cycle where the unit is busy; acks after dly cycles, then
  // checks the ack vector and whether the next start follows one cycle later.
  task automatic serve(input logic [1:0] idx, input logic [31:0] res, input int dly,
                       input bit more, input bit rp_en, input logic [1:0] rp,
                       input logic [31:0] rp_rs1, input bit dup);
    repeat (dly) step();
    exp_ack.push_back('{idx, res});
    i_m_ack = 1'b1;
    i_m_res = res;
    if (dup) set_req(idx, 32'hbad0_0000, 32'hbad0_0001, 3'd7, 1'b0);
    step();
    i_m_ack  = 1'b0;
    i_m_res  = '0;
    i_req_en = '0;
    check("ack_vec", o_req_ack, 3'(1) << idx);
    if (rp_en) set_req(rp, rp_rs1, rp_rs1 + 32'd1, 3'(rp), 1'b1);
    step();
    i_req_en = '0;
    check("next_start", o_m_en, more);
  endtask

  task automatic apply_reset();
    i_rst    = 1'b0;
    i_req_en = '0;
    i_m_ack  = 1'b0;
    exp_iss.delete();
    exp_ack.delete();
    step();
    step();
    i_rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    apply_reset();
    check("rst_m_en", o_m_en, 0);
    check("rst_m_ops", {o_m_rs1, o_m_rs2, o_m_f3}, 0);
    check("rst_ack", o_req_ack, 0);
    check("rst_res", o_req_res, 0);

    // Single request with exact issue and ack timing.
    set_req(0, 32'd6, 32'd7, 3'd0, 1'b1);
    step();
    i_req_en = '0;
    check("t1_no_start", o_m_en, 0);
    step();
    check("t2_start", o_m_en, 1);
    check("t2_ops", {o_m_rs1, o_m_rs2, o_m_f3}, {32'd6, 32'd7, 3'd0});
    serve(0, 32'd42, 3, 1'b0, 1'b0, 0, 0, 1'b0);
    check("t7_ack_low", o_req_ack, 0);
    check("t7_res_held", o_req_res[0], 32'd42);

    // Simultaneous requests after reset: grants in order 0,1,2.
    apply_reset();
    for (int k = 0; k < N; k++) begin
      set_req(2'(k), 32'd10 + 32'(k), 32'd20 + 32'(k), 3'(k), 1'b1);
    end
    step();
    i_req_en = '0;
    wait_en(4);
    serve(0, 32'd100, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    serve(1, 32'd101, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    serve(2, 32'd102, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("sim_res0", o_req_res[0], 32'd100);
    check("sim_res1", o_req_res[1], 32'd101);

    // Fairness: requester 0 re-requests after each ack, 1 is still served.
    apply_reset();
    set_req(0, 32'h30, 32'h31, 3'd0, 1'b1);
    set_req(1, 32'h32, 32'h33, 3'd1, 1'b1);
    step();
    i_req_en = '0;
    wait_en(4);
    serve(0, 32'h300, 2, 1'b1, 1'b1, 0, 32'h40, 1'b0);
    serve(1, 32'h301, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    serve(0, 32'h302, 1, 1'b0, 1'b1, 0, 32'h50, 1'b0);
    wait_en(4);
    serve(0, 32'h303, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Duplicate pulses while pending (also in the ack cycle) are ignored.
    set_req(1, 32'h11, 32'h22, 3'd5, 1'b1);
    step();
    set_req(1, 32'h99, 32'h98, 3'd2, 1'b0);
    step();
    i_req_en = '0;
    check("dup_start", o_m_en, 1);
    check("dup_ops", {o_m_rs1, o_m_rs2, o_m_f3}, {32'h11, 32'h22, 3'd5});
    step();
    set_req(1, 32'h55, 32'h56, 3'd3, 1'b0);
    step();
    i_req_en = '0;
    serve(1, 32'h77, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    repeat (4) step();
    check("dup_no_restart", o_m_en, 0);

    // Ack while idle changes nothing; ack in the start cycle is accepted.
    i_m_ack = 1'b1;
    i_m_res = 32'hdead;
    step();
    i_m_ack = 1'b0;
    check("idle_ack", o_req_ack, 0);
    check("idle_res_held", o_req_res[1], 32'h77);
    step();
    check("idle_no_start", o_m_en, 0);
    set_req(2, 32'd5, 32'd6, 3'd1, 1'b1);
    step();
    i_req_en = '0;
    wait_en(4);
    serve(2, 32'habc, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("fast_res", o_req_res[2], 32'habc);

    // Reset mid-operation with two requests pending.
    set_req(1, 32'h61, 32'h62, 3'd4, 1'b1);
    set_req(2, 32'h71, 32'h72, 3'd6, 1'b0);
    step();
    i_req_en = '0;
    wait_en(4);
    step();
    i_rst = 1'b0;
    #1;
    exp_iss.delete();
    exp_ack.delete();
    check("mid_rst_m_en", o_m_en, 0);
    check("mid_rst_ops", {o_m_rs1, o_m_rs2, o_m_f3}, 0);
    check("mid_rst_ack", o_req_ack, 0);
    check("mid_rst_res", o_req_res, 0);
    step();
    i_rst = 1'b1;
    repeat (4) step();
    check("post_rst_idle", o_m_en, 0);
    set_req(1, 32'h81, 32'h82, 3'd1, 1'b0);
    set_req(0, 32'h91, 32'h92, 3'd2, 1'b0);
    exp_iss.push_back('{32'h91, 32'h92, 3'd2});
    exp_iss.push_back('{32'h81, 32'h82, 3'd1});
    step();
    i_req_en = '0;
    wait_en(4);
    serve(0, 32'h900, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    serve(1, 32'h800, 1, 1'b0, 1'b0, 0, 0, 1'b0);

    repeat (3) step();
    check("iss_queue_drained", exp_iss.size(), 0);
    check("ack_queue_drained", exp_ack.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_m_arbiter.md
# rv32_m_arbiter

Shares one external RV32M multiply/divide unit among `N_REQ` cores, each built with `__RV32_M_EXTERNAL`. It sits between the per-core EX-stage M interfaces and a single `rv32_m` instance. It latches each core's one-cycle request pulse and operands, then grants requests round-robin. It issues one operation at a time to the unit and returns the result and a one-cycle ack to the originating core.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8).
- `XLEN`, `` `XLEN ``, operand/result width.

Ports:
- `i_clk`  in  1  clock. The block uses one clock only.
- `i_rst`  in  1  reset. Asynchronous and active-low.
- `i_req_en`  in  N_REQ  per-requester one-cycle request pulse (the core's `o_en`).
- `i_req_rs1`  in  N_REQ×XLEN  per-requester operand 1.
- `i_req_rs2`  in  N_REQ×XLEN  per-requester operand 2.
- `i_req_f3`  in  N_REQ×3  per-requester funct3.
- `o_req_ack`  out  N_REQ  per-requester one-cycle completion pulse.
- `o_req_res`  out  N_REQ×XLEN  per-requester result. Valid while `o_req_ack` is high and held afterwards.
- `o_m_en`  out  1  one-cycle start pulse to the M unit.
- `o_m_rs1`  out  XLEN  operand 1 to the M unit.
- `o_m_rs2`  out  XLEN  operand 2 to the M unit.
- `o_m_f3`  out  3  funct3 to the M unit.
- `i_m_res`  in  XLEN  M unit result, sampled with `i_m_ack`.
- `i_m_ack`  in  1  M unit done.

## Operation
- Each requester has one slot: a `pending` bit plus captured `rs1`/`rs2`/`f3`.
- When `i_req_en[k]` is sampled high and `pending[k]` is 0:
  - the slot captures the operands;
  - `pending[k]` is set at the next edge.
- When `i_req_en[k]` is sampled high and `pending[k]` is already 1, the pulse is ignored. This includes the cycle in which the requester's ack is generated. The slot is not overwritten.
- The FSM has two states, IDLE and BUSY.
  - IDLE:
    - If any `pending` bit is set, pick the winner `g` round-robin. The search starts at `last_grant+1` and wraps modulo `N_REQ`.
    - Register `o_m_rs1`/`o_m_rs2`/`o_m_f3` from slot `g` and set `o_m_en`=1.
    - Store `g` as `grant` and go to BUSY.
  - BUSY:
    - `o_m_en` is 0 from the second BUSY cycle on.
    - When `i_m_ack` is sampled high: `o_req_res[grant]` ← `i_m_res`, `o_req_ack[grant]`=1 for one cycle, `pending[grant]` ← 0, `last_grant` ← `grant`, and go to IDLE.
- `i_m_ack` is ignored in IDLE. It is accepted in BUSY on any cycle, including the cycle in which `o_m_en` is high.
- `o_m_rs1`/`o_m_rs2`/`o_m_f3` hold stable for the whole BUSY period.
- Only one requester is ever granted at a time. A requester's pending bit is never cleared without its ack.
- Arbitration is fair: a pending requester is granted within `N_REQ` grants.

## Timing
- All outputs are registered.
- Reset values: `o_m_en`=0, `o_m_rs1`/`o_m_rs2`/`o_m_f3`=0, `o_req_ack`=0, `o_req_res`=0, `pending`=0, state=IDLE, `last_grant`=`N_REQ-1` (so requester 0 wins first after reset).
- Request at cycle T0 (pulse sampled) → `pending` set at T1 → `o_m_en` high during T2. Issue latency is 2 cycles.
- `i_m_ack` sampled at Ta → `o_req_ack`/`o_req_res` valid during Ta+1. State is IDLE at Ta+1, so the next grant's `o_m_en` can be high at Ta+2.
- Back-to-back requests therefore have a 1-cycle gap between an ack and the next start.
- Reset asserted mid-operation clears all state immediately. An in-flight M-unit result is dropped, and cores are expected to be reset in the same domain.
- A requester's own new pulse is accepted from the cycle its ack is visible (Ta+1) onward.

## Structure
- Shared package `rv32_m_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_BUSY`);
  - the `m_req_t` struct {`rs1`, `rs2`, `f3`};
  - localparam `F3_W`=3.
- `XLEN` comes from `arvi_defines.svh`.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Parameter: `N`.
  - Inputs: `i_req[N]`, `i_last[$clog2(N)]`.
  - Outputs: `o_valid`, `o_grant_idx`.
- The top level holds the slot registers and the FSM.
- Target size: about 200 RTL lines.

## Test plan
- Single request: requester 0 pulses with rs1=6, rs2=7, f3=0 at T0. Required: `o_m_en`=1 at T2 with rs1/rs2/f3 = 6/7/0. Drive `i_m_ack`=1 with `i_m_res`=42 at T5 → `o_req_ack[0]`=1 and `o_req_res[0]`=42 at T6, with no other ack.
- Simultaneous requests: all `N_REQ` requesters pulse in the same cycle after reset. Required: grants are issued in order 0,1,…,N_REQ-1. Each ack routes to the correct index with distinct results, and the next `o_m_en` comes 2 cycles after each `i_m_ack`.
- Round-robin fairness: requester 0 re-requests immediately after every ack while requester 1 has one pending request. Required: requester 1 is granted on the next arbitration and is not starved.
- Duplicate pulse: requester 1 pulses again with different operands while pending. Required: the original operands are issued, and only one `o_m_en` and one ack occur.
- Ack in the start cycle: `i_m_ack`=1 in the same cycle as `o_m_en`. Required: ack and result follow next cycle. `i_m_ack` pulsed while IDLE → no output change.
- Reset mid-operation: assert `i_rst`=0 during BUSY with two requests pending. Required: all outputs and `pending` read 0 immediately. After release, requester 0 has priority.
